// File: rtl/harmonic_sequencer.sv
`timescale 1ns/1ps
// harmonic_sequencer
// Per-sample control sequencer for the additive synthesis engine. Each
// sample period it walks harmonics 0..L-1 through the sample-position,
// scaler and adder handshakes. Each harmonic is steered to channel
// (harmonic mod NUM_CH). At the end of the walk it latches the totals and
// clears the accumulators. The DAC send is issued on a fixed-rate tick.
//
// Ports
//   i_Clock            main clock
//   reset_n            asynchronous active-low reset
//   i_Max_Harmonics    runtime harmonic limit, clamped to 1..MAX_HARMONICS
//   i_Sample_Ready     sample-position value valid
//   i_Freq_Too_High    current harmonic above Nyquist, ends the walk
//   i_Scaler_Ready     per-channel scaler result valid
//   i_Adder_Ready      per-channel adder idle
//   i_Overrun_Clr      clears o_Overrun
//   o_Harmonic         current harmonic index
//   o_Next_Sample      1-cycle request for the next sample lookup
//   o_Scaler_Start     1-cycle per-channel scaler step
//   o_Scaler_Restart   1-cycle reload of the scaler initial values
//   o_Adder_Start      1-cycle per-channel accumulate strobe
//   o_Adder_Clear      1-cycle accumulator clear
//   o_Latch            1-cycle strobe, parent registers the adder totals
//   o_DAC_Send         1-cycle DAC transfer start
//   o_Harmonic_Count   harmonics accumulated in the last sample
//   o_Overrun          sticky, a tick arrived before the walk finished
//
// state       | meaning
// ------------+-----------------------------------------------------------
// WAIT_TICK   | idle, waiting for the sample tick or a deferred send
// WAIT_SAMPLE | waiting for the sample value and an idle adder on this channel
// NEXT        | decide whether to end the walk or advance the harmonic
// SCALE_START | step the scaler of the new harmonic's channel
// SCALE_WAIT  | waiting for the scaler result
// LATCH       | waiting for all adders idle, then strobe the totals
// CLEAR       | clear the accumulators

module harmonic_sequencer #(
    parameter int HARM_BITS       = 8,
    parameter int NUM_CH          = 2,
    parameter int CH_BITS         = 1,
    parameter int MAX_HARMONICS   = 100,
    parameter int TIMER_BITS      = 16,
    parameter int SAMPLE_INTERVAL = 1000
) (
    input  logic                 i_Clock,
    input  logic                 reset_n,
    input  logic [HARM_BITS-1:0] i_Max_Harmonics,
    input  logic                 i_Sample_Ready,
    input  logic                 i_Freq_Too_High,
    input  logic [NUM_CH-1:0]    i_Scaler_Ready,
    input  logic [NUM_CH-1:0]    i_Adder_Ready,
    input  logic                 i_Overrun_Clr,
    output logic [HARM_BITS-1:0] o_Harmonic,
    output logic                 o_Next_Sample,
    output logic [NUM_CH-1:0]    o_Scaler_Start,
    output logic                 o_Scaler_Restart,
    output logic [NUM_CH-1:0]    o_Adder_Start,
    output logic                 o_Adder_Clear,
    output logic                 o_Latch,
    output logic                 o_DAC_Send,
    output logic [HARM_BITS-1:0] o_Harmonic_Count,
    output logic                 o_Overrun
);

    // A single-channel build still needs a 1-bit channel index (always 0).
    localparam int CHW = (CH_BITS < 1) ? 1 : CH_BITS;

    typedef enum logic [2:0] {
        WAIT_TICK,
        WAIT_SAMPLE,
        NEXT,
        SCALE_START,
        SCALE_WAIT,
        LATCH,
        CLEAR
    } state_t;

    state_t                state;
    state_t                state_nx;

    logic [TIMER_BITS-1:0] timer;
    logic                  tick;
    logic                  missed;

    logic [HARM_BITS-1:0]  limit;
    logic [HARM_BITS-1:0]  limit_nx;
    logic [HARM_BITS-1:0]  limit_in;
    logic [HARM_BITS-1:0]  limit_last;
    logic                  pending;
    logic                  pending_nx;

    logic [CHW-1:0]        ch;
    logic [NUM_CH-1:0]     ch_sel;
    logic                  adder_ok;
    logic                  scaler_ok;
    logic                  all_idle;

    logic [HARM_BITS-1:0]  harm_nx;
    logic [HARM_BITS-1:0]  count_nx;
    logic                  next_sample_nx;
    logic [NUM_CH-1:0]     scaler_start_nx;
    logic                  scaler_restart_nx;
    logic [NUM_CH-1:0]     adder_start_nx;
    logic                  adder_clear_nx;
    logic                  latch_nx;
    logic                  dac_send_nx;
    logic                  overrun_nx;

    // The sample timer is never touched by the FSM, so the send rate stays
    // exact even when a walk overruns its period.
    assign tick = (timer == TIMER_BITS'(SAMPLE_INTERVAL - 1));

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // A tick outside WAIT_TICK, including the CLEAR->WAIT_TICK cycle, is
    // an overrun and is remembered as a single deferred send.
    assign missed = tick && (state != WAIT_TICK);

    always_comb begin
        if (i_Max_Harmonics == '0) begin
            limit_in = HARM_BITS'(1);
        end else if (i_Max_Harmonics > HARM_BITS'(MAX_HARMONICS)) begin
            limit_in = HARM_BITS'(MAX_HARMONICS);
        end else begin
            limit_in = i_Max_Harmonics;
        end
    end

    // The latched limit is at least 1, so this never wraps.
    assign limit_last = limit - 1'b1;

    always_comb begin
        if (NUM_CH == 1) begin
            ch = '0;
        end else begin
            ch = o_Harmonic[CHW-1:0];
        end
    end

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (ch == CHW'(i));
        end
    end

    assign adder_ok = |(i_Adder_Ready & ch_sel);
    assign all_idle = &i_Adder_Ready;
    // The scaler ready seen while our own start pulse is still high belongs
    // to the previous step, so it is ignored.
    assign scaler_ok = (|(i_Scaler_Ready & ch_sel)) && (o_Scaler_Start == '0);

    always_comb begin
        state_nx          = state;
        harm_nx           = o_Harmonic;
        limit_nx          = limit;
        count_nx          = o_Harmonic_Count;
        next_sample_nx    = 1'b0;
        scaler_start_nx   = '0;
        scaler_restart_nx = 1'b0;
        adder_start_nx    = '0;
        adder_clear_nx    = 1'b0;
        latch_nx          = 1'b0;
        dac_send_nx       = 1'b0;
        pending_nx        = pending | missed;
        // A set in the same cycle as a clear wins.
        overrun_nx        = missed ? 1'b1 : (i_Overrun_Clr ? 1'b0 : o_Overrun);

        case (state)
            WAIT_TICK: begin
                if (tick || pending) begin
                    // Harmonic 0 runs on the scaler initial value, so it
                    // gets a restart and no scaler step.
                    dac_send_nx       = 1'b1;
                    scaler_restart_nx = 1'b1;
                    next_sample_nx    = 1'b1;
                    harm_nx           = '0;
                    limit_nx          = limit_in;
                    pending_nx        = 1'b0;
                    state_nx          = WAIT_SAMPLE;
                end
            end
            WAIT_SAMPLE: begin
                if (i_Sample_Ready && adder_ok) begin
                    adder_start_nx = ch_sel;
                    state_nx       = NEXT;
                end
            end
            NEXT: begin
                if ((o_Harmonic >= limit_last) || i_Freq_Too_High) begin
                    state_nx = LATCH;
                end else begin
                    harm_nx        = o_Harmonic + 1'b1;
                    next_sample_nx = 1'b1;
                    state_nx       = SCALE_START;
                end
            end
            SCALE_START: begin
                // o_Harmonic already holds the new index here.
                scaler_start_nx = ch_sel;
                state_nx        = SCALE_WAIT;
            end
            SCALE_WAIT: begin
                if (scaler_ok) begin
                    state_nx = WAIT_SAMPLE;
                end
            end
            LATCH: begin
                if (all_idle) begin
                    latch_nx = 1'b1;
                    count_nx = o_Harmonic + 1'b1;
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                adder_clear_nx = 1'b1;
                state_nx       = WAIT_TICK;
            end
            default: begin
                state_nx = WAIT_TICK;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= WAIT_TICK;
            limit            <= HARM_BITS'(1);
            pending          <= 1'b0;
            o_Harmonic       <= '0;
            o_Next_Sample    <= 1'b0;
            o_Scaler_Start   <= '0;
            o_Scaler_Restart <= 1'b0;
            o_Adder_Start    <= '0;
            o_Adder_Clear    <= 1'b0;
            o_Latch          <= 1'b0;
            o_DAC_Send       <= 1'b0;
            o_Harmonic_Count <= '0;
            o_Overrun        <= 1'b0;
        end else begin
            state            <= state_nx;
            limit            <= limit_nx;
            pending          <= pending_nx;
            o_Harmonic       <= harm_nx;
            o_Next_Sample    <= next_sample_nx;
            o_Scaler_Start   <= scaler_start_nx;
            o_Scaler_Restart <= scaler_restart_nx;
            o_Adder_Start    <= adder_start_nx;
            o_Adder_Clear    <= adder_clear_nx;
            o_Latch          <= latch_nx;
            o_DAC_Send       <= dac_send_nx;
            o_Harmonic_Count <= count_nx;
            o_Overrun        <= overrun_nx;
        end
    end

endmodule

// File: doc/harmonic_sequencer.md
Name: harmonic_sequencer

Overview:
- Parametrised per-sample control sequencer for the additive engine.
- Per sample period it walks harmonics 0..N-1 through the handshakes with the sample-position, scaler and adder blocks, steering each harmonic to channel (harmonic mod NUM_CH).
- At the end it latches totals, clears the accumulators and issues the DAC send on a fixed-rate tick.
- Additions: runtime harmonic limit, adder-ready gating, any power-of-2 channel count, and overrun detection with a deferred send.

Parameters:
HARM_BITS, 8, width of harmonic index and limit
NUM_CH, 2, adder/scaler channels; power of 2, 1..8
CH_BITS, 1, log2(NUM_CH); 0 is treated as 1 with channel always 0
MAX_HARMONICS, 100, hard ceiling on harmonics per sample
TIMER_BITS, 16, sample timer width
SAMPLE_INTERVAL, 1000, clocks per sample period (48 MHz / 48 kHz)

Ports:
i_Clock  in  1  main 48 MHz clock
reset_n  in  1  asynchronous active-low reset
i_Max_Harmonics  in  HARM_BITS  runtime harmonic count limit
i_Sample_Ready  in  1  sample-position value valid
i_Freq_Too_High  in  1  current harmonic above Nyquist; terminate loop
i_Scaler_Ready  in  NUM_CH  scaler multiplier valid, per channel
i_Adder_Ready  in  NUM_CH  adder idle, per channel
i_Overrun_Clr  in  1  clears o_Overrun
o_Harmonic  out  HARM_BITS  current harmonic index
o_Next_Sample  out  1  1-cycle request for next sample lookup
o_Scaler_Start  out  NUM_CH  1-cycle scaler step, per channel
o_Scaler_Restart  out  1  1-cycle reload of scaler initial values
o_Adder_Start  out  NUM_CH  1-cycle accumulate strobe, per channel
o_Adder_Clear  out  1  1-cycle accumulator clear
o_Latch  out  1  1-cycle strobe: parent registers adder totals
o_DAC_Send  out  1  1-cycle DAC transfer start
o_Harmonic_Count  out  HARM_BITS  harmonics accumulated in last sample
o_Overrun  out  1  sticky: tick arrived before loop finished

Behaviour:
- All outputs registered. On reset: all outputs 0, timer 0, state WAIT_TICK, pending flag 0.
- Timer: free-running 0..SAMPLE_INTERVAL-1, wraps. tick = (timer == SAMPLE_INTERVAL-1). Never reset by the FSM, so sample rate is exact.
- Channel index ch = o_Harmonic[CH_BITS-1:0].
- Effective limit L = clamp(i_Max_Harmonics, 1, MAX_HARMONICS). Latched only at sample start.
- States and transitions:
  - WAIT_TICK: on tick or pending:
    - pulse o_DAC_Send, o_Scaler_Restart and o_Next_Sample.
    - o_Harmonic <= 0; latch L; clear pending.
    - go to WAIT_SAMPLE.
    - Harmonic 0 uses the scaler initial value; no scaler step.
  - WAIT_SAMPLE: when i_Sample_Ready && i_Adder_Ready[ch], pulse o_Adder_Start[ch] and go to NEXT. Wait indefinitely otherwise.
  - NEXT:
    - if (o_Harmonic >= L-1) or i_Freq_Too_High: go to LATCH.
    - else: o_Harmonic+1, pulse o_Next_Sample, go to SCALE_START.
  - SCALE_START: pulse o_Scaler_Start[new ch]; go to SCALE_WAIT.
  - SCALE_WAIT: i_Scaler_Ready[ch] is ignored in the cycle the start pulse is high. Once it is high afterwards, go to WAIT_SAMPLE.
  - LATCH:
    - wait until all i_Adder_Ready are high.
    - then pulse o_Latch; o_Harmonic_Count <= o_Harmonic+1; go to CLEAR.
  - CLEAR: pulse o_Adder_Clear; go to WAIT_TICK.
- Ordering guarantees:
  - o_Latch always precedes o_Adder_Clear by exactly 1 cycle.
  - o_DAC_Send ≥1 cycle after o_Adder_Clear.
- Overrun:
  - a tick while state ≠ WAIT_TICK sets o_Overrun and pending.
  - the loop completes normally; WAIT_TICK then sends on its first cycle.
  - multiple missed ticks collapse to one pending.
  - if i_Overrun_Clr coincides with a new overrun tick, set wins.
- Tick coinciding with entry to WAIT_TICK (the CLEAR→WAIT_TICK cycle): counts as overrun. Send occurs the next cycle.
- The first send after reset carries zero totals.
- Only one bit of any per-channel vector is ever high.
- A reset mid-loop abandons the sample: no latch, no clear, no send.

Test Plan:
- NUM_CH=2, L=100, ready inputs tied high → one o_DAC_Send per 1000 clocks. o_Adder_Start alternates bits 0/1. o_Harmonic_Count=100; o_Overrun=0.
- i_Freq_Too_High asserted once o_Harmonic=9 → o_Latch follows, o_Harmonic_Count=10, then o_Adder_Clear exactly 1 cycle after o_Latch.
- i_Max_Harmonics=0 → count 1; i_Max_Harmonics=200 → count 100 (clamped); limit changed mid-sample takes effect only on the next sample.
- i_Sample_Ready delayed 15 cycles per harmonic with L=100 → o_Overrun=1, o_DAC_Send one cycle after WAIT_TICK entry, timer phase unchanged.
- NUM_CH=4, i_Adder_Ready[2] held low 20 cycles → harmonic 2 start stalls, no other start bits pulse meanwhile.
- Assert reset_n=0 mid-loop → all outputs 0 immediately; after release the first send occurs 1000 clocks later.
